// File: rtl/compare_sequencer_pkg.sv
// Shared definitions for the bit-serial compare sequencer: FSM state
// encoding, default operand width and the match counter ceiling.
package compare_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int         WIDTH_DEFAULT = 8;
  localparam logic [7:0] COUNT_MAX     = 8'd255;

endpackage

// File: rtl/compare_sequencer_cmp_count_sat.sv
// Saturating event counter; a clear takes priority over an increment.
module cmp_count_sat
  import compare_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] count
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 8'd0;
    end else if (inc && (count_q != COUNT_MAX)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/compare_sequencer.sv
// Bit-serial unsigned magnitude comparator: scans MSB first, stops at the
// first differing bit and holds the result until the consumer takes it.
module compare_sequencer
  import compare_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic             busy,
  output logic [7:0]       match_count,
  input  logic             clr_count
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDX_W-1:0] idx_q;
  logic             eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
  logic             in_hs, out_hs, bit_a, bit_b;

  assign in_hs  = in_valid && (state_q == ST_IDLE);
  assign out_hs = out_ready && (state_q == ST_DONE);
  assign bit_a  = a_q[idx_q];
  assign bit_b  = b_q[idx_q];

  always_comb begin
    state_d = state_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        // Early exit on the first differing bit; the MSB decides magnitude.
        if (bit_a != bit_b) begin
          gt_d    = bit_a;
          lt_d    = bit_b;
          state_d = ST_DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        eq_d    = 1'b0;
        gt_d    = 1'b0;
        lt_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  // Operands and index are only meaningful once the FSM leaves IDLE.
  always_ff @(posedge clk) begin
    if (in_hs) begin
      a_q   <= a;
      b_q   <= b;
      idx_q <= IDX_W'(WIDTH - 1);
    end else if ((state_q == ST_SCAN) && (idx_q != '0)) begin
      idx_q <= idx_q - IDX_W'(1);
    end
  end

  cmp_count_sat u_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_hs && eq_q),
    .clr   (clr_count),
    .count (match_count)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SCAN);
  assign eq        = eq_q;
  assign gt        = gt_q;
  assign lt        = lt_q;

endmodule

// File: tb/tb_compare_sequencer.sv
// Randomized bench for compare_sequencer against a plain-arithmetic model
// of result, latency and saturating match count.
module tb_compare_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         eq, gt, lt, busy;
  logic [7:0]   match_count;
  logic         clr_count = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int mdl_cnt = 0;

  compare_sequencer #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .eq          (eq),
    .gt          (gt),
    .lt          (lt),
    .busy        (busy),
    .match_count (match_count),
    .clr_count   (clr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Latency = edges from acceptance to out_valid: WIDTH - (first differing bit), or WIDTH if equal.
  function automatic int model_latency(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i] != y[i]) return W - i;
    end
    return W;
  endfunction

  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input int hold, input bit clr_end, input bit clr_mid);
    int lat;
    int exp_lat;
    bit exp_eq, exp_gt, exp_lt;
    exp_lat = model_latency(ta, tb_v);
    exp_eq  = (ta == tb_v);
    exp_gt  = (ta > tb_v);
    exp_lt  = (ta < tb_v);

    @(negedge clk);
    a = ta; b = tb_v; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom);
    chk("busy_after_accept", busy, 1);
    chk("in_ready_scan", in_ready, 0);
    lat = 0;
    clr_count = clr_mid;
    while (!out_valid && lat < 3 * W) begin
      @(posedge clk); #1;
      if (clr_count) mdl_cnt = 0;
      clr_count = 1'b0;
      lat++;
    end
    clr_count = 1'b0;
    chk("latency", lat, exp_lat);
    chk("eq", eq, exp_eq);
    chk("gt", gt, exp_gt);
    chk("lt", lt, exp_lt);
    chk("count_during_done", match_count, mdl_cnt);

    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      a = ~ta; b = ta;
      @(posedge clk); #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_flags", {eq, gt, lt}, {exp_eq, exp_gt, exp_lt});
    end
    in_valid = 1'b0;

    out_ready = 1'b1;
    clr_count = clr_end;
    @(posedge clk); #1;
    out_ready = 1'b0;
    clr_count = 1'b0;
    if (clr_end) mdl_cnt = 0;
    else if (exp_eq && mdl_cnt < 255) mdl_cnt++;
    chk("post_out_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_flags", {eq, gt, lt}, 3'b000);
    chk("match_count", match_count, mdl_cnt);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1'b1;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_flags", {eq, gt, lt}, 3'b000);
    chk("rst_busy", busy, 0);
    chk("rst_count", match_count, 0);
    @(negedge clk);
    rst = 1'b0;

    run_txn(8'h5A, 8'h5A, 0, 0, 0);
    run_txn(8'h80, 8'h7F, 0, 0, 0);
    run_txn(8'h12, 8'h13, 0, 0, 0);
    run_txn(8'h3C, 8'h3C, 5, 0, 0);
    run_txn(8'h01, 8'h00, 5, 0, 0);

    for (int n = 0; n < 40; n++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 2))
        0: rb = W'($urandom);
        1: rb = ra ^ W'(1 << $urandom_range(0, W - 1));
        default: rb = ra;
      endcase
      run_txn(ra, rb, $urandom_range(0, 3), 0, ($urandom_range(0, 7) == 0));
    end

    // Reset while the scan sits at bit index 3 (4 edges after acceptance).
    @(negedge clk);
    a = 8'hA5; b = 8'hA5; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    mdl_cnt = 0;
    chk("midscan_rst_in_ready", in_ready, 1);
    chk("midscan_rst_busy", busy, 0);
    chk("midscan_rst_out_valid", out_valid, 0);
    chk("midscan_rst_count", match_count, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("no_result_after_rst", out_valid, 0);
    end
    out_ready = 1'b0;

    for (int n = 0; n < 260; n++) begin
      ra = W'($urandom);
      run_txn(ra, ra, 0, 0, 0);
    end
    chk("saturated_count", match_count, 255);
    run_txn(8'hC3, 8'hC3, 0, 1, 0);
    chk("clr_over_inc", match_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
